ps2_keyboard: RTL and testbench

- Upstream producer of the 5-bit keyboard column data `kd` that the I/O port block returns on port #FE reads.
- Receives PS/2 keyboard frames and tracks make/break/extended prefixes.
- Maintains an 8x5 ZX Spectrum key matrix and resolves the current half-row selection (CPU address bits 15:8) to active-low column data.
- Also raises one-cycle magic (F12) and reset (F11) requests for the machine controller.

---
 rtl/ps2_keyboard_pkg.sv | 25 ++
 rtl/ps2_zx_keymap.sv | 66 ++++++
 rtl/ps2_keyboard.sv | 197 +++++++++++++++++++
 tb/tb_ps2_keyboard.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_keyboard_pkg.sv
// Shared types for the PS/2 keyboard front end: matrix geometry and the
// key-position record produced by the scancode table.
package ps2_keyboard_pkg;

    localparam int NROWS = 8;
    localparam int NCOLS = 5;

    localparam logic [2:0] CS_ROW = 3'd0;
    localparam logic [2:0] CS_COL = 3'd0;
    localparam logic [2:0] SS_ROW = 3'd7;
    localparam logic [2:0] SS_COL = 3'd1;

    typedef struct packed {
        logic       valid;
        logic [2:0] row;
        logic [2:0] col;
    } keypos_t;

    localparam keypos_t KP_NONE = '0;

    function automatic keypos_t kp(input logic [2:0] row, input logic [2:0] col);
        return '{valid: 1'b1, row: row, col: col};
    endfunction

endpackage

// File: rtl/ps2_zx_keymap.sv
// Scancode set 2 to ZX Spectrum matrix table; compound keys (Backspace,
// cursor keys) return Caps Shift as a second position.
module ps2_zx_keymap
    import ps2_keyboard_pkg::*;
(
    input  logic       ext_i,
    input  logic [7:0] code_i,
    output keypos_t    kp0_o,
    output keypos_t    kp1_o
);

    always_comb begin
        kp0_o = KP_NONE;
        kp1_o = KP_NONE;
        case ({ext_i, code_i})
            9'h012, 9'h059: kp0_o = kp(CS_ROW, CS_COL);
            9'h01A: kp0_o = kp(3'd0, 3'd1);
            9'h022: kp0_o = kp(3'd0, 3'd2);
            9'h021: kp0_o = kp(3'd0, 3'd3);
            9'h02A: kp0_o = kp(3'd0, 3'd4);
            9'h01C: kp0_o = kp(3'd1, 3'd0);
            9'h01B: kp0_o = kp(3'd1, 3'd1);
            9'h023: kp0_o = kp(3'd1, 3'd2);
            9'h02B: kp0_o = kp(3'd1, 3'd3);
            9'h034: kp0_o = kp(3'd1, 3'd4);
            9'h015: kp0_o = kp(3'd2, 3'd0);
            9'h01D: kp0_o = kp(3'd2, 3'd1);
            9'h024: kp0_o = kp(3'd2, 3'd2);
            9'h02D: kp0_o = kp(3'd2, 3'd3);
            9'h02C: kp0_o = kp(3'd2, 3'd4);
            9'h016: kp0_o = kp(3'd3, 3'd0);
            9'h01E: kp0_o = kp(3'd3, 3'd1);
            9'h026: kp0_o = kp(3'd3, 3'd2);
            9'h025: kp0_o = kp(3'd3, 3'd3);
            9'h02E: kp0_o = kp(3'd3, 3'd4);
            9'h045: kp0_o = kp(3'd4, 3'd0);
            9'h046: kp0_o = kp(3'd4, 3'd1);
            9'h03E: kp0_o = kp(3'd4, 3'd2);
            9'h03D: kp0_o = kp(3'd4, 3'd3);
            9'h036: kp0_o = kp(3'd4, 3'd4);
            9'h04D: kp0_o = kp(3'd5, 3'd0);
            9'h044: kp0_o = kp(3'd5, 3'd1);
            9'h043: kp0_o = kp(3'd5, 3'd2);
            9'h03C: kp0_o = kp(3'd5, 3'd3);
            9'h035: kp0_o = kp(3'd5, 3'd4);
            9'h05A, 9'h15A: kp0_o = kp(3'd6, 3'd0);
            9'h04B: kp0_o = kp(3'd6, 3'd1);
            9'h042: kp0_o = kp(3'd6, 3'd2);
            9'h03B: kp0_o = kp(3'd6, 3'd3);
            9'h033: kp0_o = kp(3'd6, 3'd4);
            9'h029: kp0_o = kp(3'd7, 3'd0);
            9'h014, 9'h114: kp0_o = kp(SS_ROW, SS_COL);
            9'h03A: kp0_o = kp(3'd7, 3'd2);
            9'h031: kp0_o = kp(3'd7, 3'd3);
            9'h032: kp0_o = kp(3'd7, 3'd4);
            // Backspace and cursor keys are Caps Shift plus a digit
            9'h066: begin kp0_o = kp(CS_ROW, CS_COL); kp1_o = kp(3'd4, 3'd0); end
            9'h16B: begin kp0_o = kp(CS_ROW, CS_COL); kp1_o = kp(3'd3, 3'd4); end
            9'h172: begin kp0_o = kp(CS_ROW, CS_COL); kp1_o = kp(3'd4, 3'd4); end
            9'h175: begin kp0_o = kp(CS_ROW, CS_COL); kp1_o = kp(3'd4, 3'd3); end
            9'h174: begin kp0_o = kp(CS_ROW, CS_COL); kp1_o = kp(3'd4, 3'd2); end
            default: ;
        endcase
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard front end: conditions the PS/2 lines, decodes frames and
// maintains the ZX Spectrum key matrix returned on port #FE reads.
module ps2_keyboard
    import ps2_keyboard_pkg::*;
#(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 56000
) (
    input  logic       clk28,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic [7:0] addr_hi,
    output logic [4:0] kd,
    output logic       magic_req,
    output logic       reset_req,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Bit 0 carries ps2_clk, bit 1 carries ps2_dat
    logic [1:0]    sync1_q, sync2_q, filt_q;
    logic [FW-1:0] fcnt_q [2];
    logic          clk_prev_q;
    logic          fall;

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            filt_q     <= 2'b11;
            clk_prev_q <= 1'b1;
            fcnt_q[0]  <= '0;
            fcnt_q[1]  <= '0;
        end else begin
            sync1_q    <= {ps2_dat, ps2_clk};
            sync2_q    <= sync1_q;
            clk_prev_q <= filt_q[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FW'(FILTER - 1)) begin
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign fall = clk_prev_q & ~filt_q[0];

    state_t        state_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q, code_q;
    logic          par_q, code_vld_q, abort_q, frame_err_q;
    logic [TW-1:0] tmo_q;

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_q       <= '0;
            shift_q     <= '0;
            code_q      <= '0;
            par_q       <= 1'b0;
            code_vld_q  <= 1'b0;
            abort_q     <= 1'b0;
            frame_err_q <= 1'b0;
            tmo_q       <= '0;
        end else begin
            code_vld_q  <= 1'b0;
            abort_q     <= 1'b0;
            frame_err_q <= 1'b0;
            if (state_q == IDLE || fall) tmo_q <= '0;
            else                         tmo_q <= tmo_q + 1'b1;

            if (state_q != IDLE && !fall && tmo_q == TW'(TIMEOUT - 1)) begin
                state_q     <= IDLE;
                abort_q     <= 1'b1;
                frame_err_q <= 1'b1;
            end else if (fall) begin
                case (state_q)
                    IDLE: if (!filt_q[1]) begin
                        state_q <= DATA;
                        bit_q   <= '0;
                    end
                    DATA: begin
                        shift_q[bit_q] <= filt_q[1];
                        bit_q          <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= PARITY;
                    end
                    PARITY: begin
                        par_q   <= filt_q[1];
                        state_q <= STOP;
                    end
                    STOP: begin
                        if (filt_q[1] && (^{shift_q, par_q})) begin
                            code_vld_q <= 1'b1;
                            code_q     <= shift_q;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    keypos_t                        kp0, kp1;
    logic [NROWS-1:0][NCOLS-1:0]    matrix_q;
    logic                           ext_q, brk_q, magic_held_q, reset_held_q;
    logic                           magic_q, reset_q;
    logic [4:0]                     kd_q, kd_d;

    ps2_zx_keymap u_keymap (
        .ext_i  (ext_q),
        .code_i (code_q),
        .kp0_o  (kp0),
        .kp1_o  (kp1)
    );

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            matrix_q     <= '0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            magic_held_q <= 1'b0;
            reset_held_q <= 1'b0;
            magic_q      <= 1'b0;
            reset_q      <= 1'b0;
        end else begin
            magic_q <= 1'b0;
            reset_q <= 1'b0;
            if (abort_q) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (code_vld_q) begin
                case (code_q)
                    8'hE0: ext_q <= 1'b1;
                    8'hF0: brk_q <= 1'b1;
                    8'hAA, 8'h00, 8'hFF: begin
                        matrix_q <= '0;
                        ext_q    <= 1'b0;
                        brk_q    <= 1'b0;
                    end
                    default: begin
                        if (kp0.valid) matrix_q[kp0.row][kp0.col] <= !brk_q;
                        if (kp1.valid) matrix_q[kp1.row][kp1.col] <= !brk_q;
                        // Held flags suppress typematic repeats of F12/F11
                        if (!ext_q && code_q == 8'h07) begin
                            if (brk_q) begin
                                magic_held_q <= 1'b0;
                            end else if (!magic_held_q) begin
                                magic_held_q <= 1'b1;
                                magic_q      <= 1'b1;
                            end
                        end
                        if (!ext_q && code_q == 8'h78) begin
                            if (brk_q) begin
                                reset_held_q <= 1'b0;
                            end else if (!reset_held_q) begin
                                reset_held_q <= 1'b1;
                                reset_q      <= 1'b1;
                            end
                        end
                        ext_q <= 1'b0;
                        brk_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        kd_d = 5'b11111;
        for (int r = 0; r < NROWS; r++) begin
            if (!addr_hi[r]) kd_d = kd_d & ~matrix_q[r];
        end
    end

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) kd_q <= 5'b11111;
        else     kd_q <= kd_d;
    end

    assign kd        = kd_q;
    assign magic_req = magic_q;
    assign reset_req = reset_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Scoreboard bench for ps2_keyboard: a key-name level model of the Spectrum
// keyboard predicts kd and the request/error pulses.
`timescale 1ns/1ps
module tb_ps2_keyboard;
    localparam int FILTER  = 8;
    localparam int TIMEOUT = 300;
    localparam int HALF    = 16;
    localparam int EV_ERR = 1, EV_MAGIC = 2, EV_RESET = 3;

    logic       clk28 = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_dat = 1'b1;
    logic [7:0] addr_hi = 8'hFF;
    logic [4:0] kd;
    logic       magic_req, reset_req, frame_err;

    ps2_keyboard #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clk28(clk28), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .addr_hi(addr_hi), .kd(kd), .magic_req(magic_req),
        .reset_req(reset_req), .frame_err(frame_err)
    );

    always #5 clk28 = ~clk28;

    int total = 0, bad = 0, magic_seen = 0;
    int exp_q[$];

    // Model: keyboard drawn as character rows; '^'=CS, '$'=SS, '*'=Enter
    string layout[8] = '{"^ZXCV", "ASDFG", "QWERT", "12345", "09876", "POIUY", "*LKJH", " $MNB"};
    bit key_dn[8][5];
    bit m_ext, m_brk, m_mheld, m_rheld;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic string keys_of(input bit ext, input logic [7:0] c);
        if (ext) begin
            case (c)
                8'h6B: return "^5";  8'h72: return "^6";
                8'h75: return "^7";  8'h74: return "^8";
                8'h5A: return "*";   8'h14: return "$";
                default: return "";
            endcase
        end
        case (c)
            8'h12, 8'h59: return "^";
            8'h1A: return "Z"; 8'h22: return "X"; 8'h21: return "C"; 8'h2A: return "V";
            8'h1C: return "A"; 8'h1B: return "S"; 8'h23: return "D"; 8'h2B: return "F"; 8'h34: return "G";
            8'h15: return "Q"; 8'h1D: return "W"; 8'h24: return "E"; 8'h2D: return "R"; 8'h2C: return "T";
            8'h16: return "1"; 8'h1E: return "2"; 8'h26: return "3"; 8'h25: return "4"; 8'h2E: return "5";
            8'h45: return "0"; 8'h46: return "9"; 8'h3E: return "8"; 8'h3D: return "7"; 8'h36: return "6";
            8'h4D: return "P"; 8'h44: return "O"; 8'h43: return "I"; 8'h3C: return "U"; 8'h35: return "Y";
            8'h5A: return "*"; 8'h4B: return "L"; 8'h42: return "K"; 8'h3B: return "J"; 8'h33: return "H";
            8'h29: return " "; 8'h14: return "$"; 8'h3A: return "M"; 8'h31: return "N"; 8'h32: return "B";
            8'h66: return "^0";
            default: return "";
        endcase
    endfunction

    function automatic void model_clear();
        foreach (key_dn[r, c]) key_dn[r][c] = 1'b0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        string k, row;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hAA || b == 8'h00 || b == 8'hFF) begin
            model_clear();
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
            k = keys_of(m_ext, b);
            for (int i = 0; i < k.len(); i++)
                for (int r = 0; r < 8; r++) begin
                    row = layout[r];
                    for (int c = 0; c < 5; c++)
                        if (row.getc(c) == k.getc(i)) key_dn[r][c] = !m_brk;
                end
            if (!m_ext && b == 8'h07) begin
                if (m_brk) m_mheld = 1'b0;
                else if (!m_mheld) begin m_mheld = 1'b1; exp_q.push_back(EV_MAGIC); end
            end
            if (!m_ext && b == 8'h78) begin
                if (m_brk) m_rheld = 1'b0;
                else if (!m_rheld) begin m_rheld = 1'b1; exp_q.push_back(EV_RESET); end
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    function automatic logic [4:0] model_kd(input logic [7:0] a);
        logic [4:0] res = 5'b11111;
        for (int r = 0; r < 8; r++)
            if (!a[r])
                for (int c = 0; c < 5; c++)
                    if (key_dn[r][c]) res[c] = 1'b0;
        return res;
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_dat = bits[i];
            repeat (HALF) @(posedge clk28);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk28);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par);
        logic par;
        par = (~^b) ^ bad_par;
        if (bad_par) exp_q.push_back(EV_ERR);
        else         model_byte(b);
        send_bits({1'b1, par, b, 1'b0}, 11);
        repeat (2 * HALF) @(posedge clk28);
    endtask

    task automatic set_addr(input logic [7:0] a);
        @(negedge clk28);
        addr_hi = a;
        @(posedge clk28);
        #1;
    endtask

    task automatic pop_event(input int kind);
        int e;
        if (exp_q.size() == 0) chk("unexpected_pulse", kind, 0);
        else begin
            e = exp_q.pop_front();
            chk("pulse_kind", kind, e);
        end
    endtask

    always @(negedge clk28) begin
        if (!rst) begin
            if (frame_err) pop_event(EV_ERR);
            if (magic_req) begin magic_seen++; pop_event(EV_MAGIC); end
            if (reset_req) pop_event(EV_RESET);
        end
    end

    logic [7:0] pool[] = '{8'h1C, 8'h12, 8'h59, 8'h1A, 8'h22, 8'h21, 8'h2A, 8'h1B, 8'h23,
                           8'h2B, 8'h34, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h16, 8'h1E,
                           8'h26, 8'h25, 8'h2E, 8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36, 8'h4D,
                           8'h44, 8'h43, 8'h3C, 8'h35, 8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,
                           8'h29, 8'h14, 8'h3A, 8'h31, 8'h32, 8'h66, 8'h6B, 8'h72, 8'h75,
                           8'h74, 8'h07, 8'h78, 8'h0D, 8'hAA};

    initial begin
        int m0;
        logic [7:0] a;
        model_clear();
        m_ext = 0; m_brk = 0; m_mheld = 0; m_rheld = 0;

        repeat (3) @(posedge clk28);
        #1;
        chk("reset_kd", kd, 5'b11111);
        chk("reset_magic", magic_req, 0);
        chk("reset_reset", reset_req, 0);
        chk("reset_err", frame_err, 0);
        @(negedge clk28) rst = 1'b0;
        repeat (4) @(posedge clk28);

        send_byte(8'h1C, 0);
        set_addr(8'hFD);
        chk("A_make", kd, 5'b11110);
        send_byte(8'hF0, 0); send_byte(8'h1C, 0);
        chk("A_break", kd, 5'b11111);

        set_addr(8'hF6);
        send_byte(8'hE0, 0); send_byte(8'h6B, 0);
        chk("left_make", kd, 5'b01110);
        send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h6B, 0);
        chk("left_break", kd, 5'b11111);

        set_addr(8'h7F);
        send_byte(8'h29, 1);
        chk("badpar_kd", kd, 5'b11111);
        send_byte(8'h29, 0);
        chk("space_make", kd, 5'b11110);

        send_byte(8'hE0, 0);
        exp_q.push_back(EV_ERR);
        m_ext = 1'b0; m_brk = 1'b0;
        send_bits({6'h0, 4'b1010, 1'b0}, 5);
        repeat (TIMEOUT + 10) @(posedge clk28);
        send_byte(8'h5A, 0);
        set_addr(8'hBF);
        chk("enter_after_tmo", kd, 5'b11110);

        send_byte(8'h1C, 0); send_byte(8'h12, 0);
        set_addr(8'h00);
        chk("a_shift_held", kd, model_kd(8'h00));
        send_byte(8'hAA, 0);
        chk("bat_clear", kd, 5'b11111);

        m0 = magic_seen;
        send_byte(8'h07, 0); send_byte(8'h07, 0);
        send_byte(8'hF0, 0); send_byte(8'h07, 0);
        send_byte(8'h07, 0);
        chk("magic_count", magic_seen - m0, 2);
        send_byte(8'h78, 0); send_byte(8'h78, 0);

        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(3) == 0) send_byte(8'hE0, $urandom_range(9) == 0);
            if ($urandom_range(2) == 0) send_byte(8'hF0, 0);
            send_byte(pool[$urandom_range(pool.size() - 1)], $urandom_range(9) == 0);
            a = 8'($urandom);
            set_addr(a);
            chk("rand_kd", kd, model_kd(a));
        end

        send_byte(8'hAA, 0);
        send_byte(8'h1C, 0);
        set_addr(8'hFD);
        chk("pre_rst_kd", kd, 5'b11110);
        send_bits({6'h0, 4'b0110, 1'b0}, 5);
        @(negedge clk28);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_kd", kd, 5'b11111);
        chk("rst_mid_magic", magic_req, 0);
        chk("rst_mid_err", frame_err, 0);
        model_clear();
        m_ext = 0; m_brk = 0; m_mheld = 0; m_rheld = 0;
        ps2_clk = 1'b1; ps2_dat = 1'b1;
        repeat (5) @(posedge clk28);
        @(negedge clk28) rst = 1'b0;
        repeat (4) @(posedge clk28);
        send_byte(8'h1C, 0);
        chk("post_rst_A", kd, 5'b11110);

        repeat (10) @(posedge clk28);
        chk("pending_pulses", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
